// File: rtl/arm_pipe_pkg.sv
// Shared encodings for the ARM pipeline control path: forwarding selects,
// special register indices, EX control-bundle bit positions and the stall FSM states.
package arm_pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int unsigned REG_LR = 14;
  localparam int unsigned REG_PC = 15;

  // EX bundle layout {opcode,s_en,load,rf_en,size,rw,mem_en,b,bl}, bl at bit 0
  localparam int unsigned CTRL_BL     = 0;
  localparam int unsigned CTRL_B      = 1;
  localparam int unsigned CTRL_MEM_EN = 2;
  localparam int unsigned CTRL_RW     = 3;
  localparam int unsigned CTRL_SIZE   = 4;
  localparam int unsigned CTRL_RF_EN  = 5;
  localparam int unsigned CTRL_LOAD   = 6;
  localparam int unsigned CTRL_S_EN   = 7;
  localparam int unsigned CTRL_OP_LSB = 8;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } stall_st_e;

endpackage

// File: rtl/pipe_hazard_unit.sv
// Combinational load-use detection and ID operand forwarding selects.
// Zero latency; rf_en inputs must already reflect condition squash.
module pipe_hazard_unit
  import arm_pipe_pkg::*;
#(
  parameter int RW = 4
) (
  input  logic          ex_valid,
  input  logic          ex_load,
  input  logic          ex_rf_en,
  input  logic [RW-1:0] ex_rd,
  input  logic          mem_rf_en,
  input  logic [RW-1:0] mem_rd,
  input  logic          wb_rf_en,
  input  logic [RW-1:0] wb_rd,
  input  logic [RW-1:0] id_rn,
  input  logic [RW-1:0] id_rm,
  input  logic          id_use_rn,
  input  logic          id_use_rm,
  output logic          load_use,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b
);

  // A load in EX never forwards: its data only exists from MEM onwards.
  function automatic logic [1:0] pick(input logic [RW-1:0] src);
    if (src == RW'(REG_PC))                                  return FWD_RF;
    if (ex_valid && ex_rf_en && !ex_load && (ex_rd == src))  return FWD_EX;
    if (mem_rf_en && (mem_rd == src))                        return FWD_MEM;
    if (wb_rf_en && (wb_rd == src))                          return FWD_WB;
    return FWD_RF;
  endfunction

  assign load_use = ex_valid & ex_load & ex_rf_en &
                    ((id_use_rn & (id_rn == ex_rd)) | (id_use_rm & (id_rm == ex_rd)));

  always_comb begin
    fwd_a = pick(id_rn);
    fwd_b = pick(id_rm);
  end

endmodule

// File: rtl/pipeline_ctrl_seq.sv
// Carries decoded control through ID/EX/MEM/WB with load-use stall, branch flush,
// condition squash and forwarding selects. PIPE_PERF_CNT_EN adds stall/flush/squash counters.
module pipeline_ctrl_seq
  import arm_pipe_pkg::*;
#(
  parameter int RW = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [CW-1:0] id_opcode,
  input  logic          id_s_en,
  input  logic          id_load,
  input  logic          id_rf_en,
  input  logic          id_size,
  input  logic          id_rw,
  input  logic          id_mem_en,
  input  logic          id_b,
  input  logic          id_bl,
  input  logic [RW-1:0] id_rd,
  input  logic [RW-1:0] id_rn,
  input  logic [RW-1:0] id_rm,
  input  logic          id_use_rn,
  input  logic          id_use_rm,
  input  logic          ex_cond_pass,
  output logic          pc_le,
  output logic          ifid_le,
  output logic          ifid_clr,
  output logic [CW+7:0] ex_ctrl,
  output logic          mem_load,
  output logic          mem_rf_en,
  output logic          mem_size,
  output logic          mem_rw,
  output logic          mem_en,
  output logic [RW-1:0] mem_rd,
  output logic          wb_rf_en,
  output logic [RW-1:0] wb_rd,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          branch_taken
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt,
  output logic [31:0]   squash_cnt
`endif
);

  stall_st_e     state_q;
  logic          ex_valid_q, ex_valid_d;
  logic [CW+7:0] ex_ctrl_q, ex_ctrl_d;
  logic [RW-1:0] ex_rd_q, ex_rd_d;
  logic          mem_load_q, mem_rf_en_q, mem_size_q, mem_rw_q, mem_en_q;
  logic [RW-1:0] mem_rd_q;
  logic          wb_rf_en_q;
  logic [RW-1:0] wb_rd_q;

  logic          squash, load_use, stall, bubble;
  logic [CW+7:0] ex_gated;

  assign squash = ex_valid_q & ~ex_cond_pass;

  always_comb begin
    ex_gated = ex_ctrl_q;
    if (squash) begin
      ex_gated[CTRL_RF_EN]  = 1'b0;
      ex_gated[CTRL_MEM_EN] = 1'b0;
      ex_gated[CTRL_RW]     = 1'b0;
      ex_gated[CTRL_S_EN]   = 1'b0;
      ex_gated[CTRL_B]      = 1'b0;
      ex_gated[CTRL_BL]     = 1'b0;
    end
  end

  assign branch_taken = ex_valid_q & ex_cond_pass & (ex_ctrl_q[CTRL_B] | ex_ctrl_q[CTRL_BL]);

  pipe_hazard_unit #(.RW(RW)) u_hazard (
    .ex_valid  (ex_valid_q),
    .ex_load   (ex_gated[CTRL_LOAD]),
    .ex_rf_en  (ex_gated[CTRL_RF_EN]),
    .ex_rd     (ex_rd_q),
    .mem_rf_en (mem_rf_en_q),
    .mem_rd    (mem_rd_q),
    .wb_rf_en  (wb_rf_en_q),
    .wb_rd     (wb_rd_q),
    .id_rn     (id_rn),
    .id_rm     (id_rm),
    .id_use_rn (id_use_rn),
    .id_use_rm (id_use_rm),
    .load_use  (load_use),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b)
  );

  // Branch beats load-use: the dependent instruction is being flushed anyway.
  assign stall    = (state_q == ST_RUN) & load_use & ~branch_taken;
  assign bubble   = stall | branch_taken | ~id_valid;
  assign pc_le    = ~stall;
  assign ifid_le  = ~stall;
  assign ifid_clr = branch_taken;

  always_comb begin
    ex_ctrl_d  = '0;
    ex_rd_d    = '0;
    ex_valid_d = ~bubble;
    if (!bubble) begin
      ex_ctrl_d[CTRL_OP_LSB +: CW] = id_opcode;
      ex_ctrl_d[CTRL_S_EN]         = id_s_en;
      ex_ctrl_d[CTRL_LOAD]         = id_load;
      ex_ctrl_d[CTRL_RF_EN]        = id_rf_en | id_bl;
      ex_ctrl_d[CTRL_SIZE]         = id_size;
      ex_ctrl_d[CTRL_RW]           = id_rw;
      ex_ctrl_d[CTRL_MEM_EN]       = id_mem_en;
      ex_ctrl_d[CTRL_B]            = id_b;
      ex_ctrl_d[CTRL_BL]           = id_bl;
      ex_rd_d                      = id_bl ? RW'(REG_LR) : id_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_rd_q     <= '0;
      mem_load_q  <= 1'b0;
      mem_rf_en_q <= 1'b0;
      mem_size_q  <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rd_q    <= '0;
      wb_rf_en_q  <= 1'b0;
      wb_rd_q     <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      mem_load_q  <= ex_gated[CTRL_LOAD];
      mem_rf_en_q <= ex_gated[CTRL_RF_EN];
      mem_size_q  <= ex_gated[CTRL_SIZE];
      mem_rw_q    <= ex_gated[CTRL_RW];
      mem_en_q    <= ex_gated[CTRL_MEM_EN];
      mem_rd_q    <= ex_rd_q;
      wb_rf_en_q  <= mem_rf_en_q;
      wb_rd_q     <= mem_rd_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   state_q <= stall ? ST_STALL : ST_RUN;
        ST_STALL: state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  assign ex_ctrl   = ex_gated;
  assign mem_load  = mem_load_q;
  assign mem_rf_en = mem_rf_en_q;
  assign mem_size  = mem_size_q;
  assign mem_rw    = mem_rw_q;
  assign mem_en    = mem_en_q;
  assign mem_rd    = mem_rd_q;
  assign wb_rf_en  = wb_rf_en_q;
  assign wb_rd     = wb_rd_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, squash_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (stall)        stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (branch_taken) flush_cnt_q  <= flush_cnt_q + 32'd1;
      if (squash)       squash_cnt_q <= squash_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif

endmodule
